ysyx_22040632_ifu: RTL and testbench
====================================

Name: ysyx_22040632_ifu

Overview:
Instruction fetch unit directly upstream of the decode stage that produces the func/typet classification. Holds the PC and issues one 8-byte-aligned read at a time on a valid/ready memory request channel. Selects the 32-bit instruction word from the 64-bit response and presents it to decode with a valid/ready handshake. Accepts redirects from execute (jal, jalr, beq, bne) and squashes wrong-path fetches.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset
XLEN, 64, address and response data width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  {pc[63:3],3'b000}
imem_resp_valid  in  1  read data valid; one-cycle pulse per accepted request
imem_resp_data  in  XLEN  read data
redirect_valid  in  1  execute redirect, single-cycle pulse
redirect_pc  in  XLEN  redirect target
inst_valid  out  1  instruction valid to decode
inst_ready  in  1  decode accepts instruction
inst_pc  out  XLEN  PC of presented instruction
inst  out  32  instruction word

Behaviour:
- Clock: clk only. Reset: rst, synchronous and active-high.
- Reset state: state=IDLE, pc=RESET_PC, drop=0, inst_pc=0, inst=0. imem_req_valid=0 and inst_valid=0 while in IDLE.
- pc[1:0] is forced to 2'b00 on every load; redirect_pc[1:0] is ignored.
- States: IDLE, REQ, WAIT, HOLD.
  - IDLE -> REQ unconditionally. First request appears 1 cycle after rst falls.
  - REQ: imem_req_valid=1. On imem_req_valid && imem_req_ready, go to WAIT.
  - WAIT: on imem_resp_valid with drop=0, latch inst = pc[2] ? data[63:32] : data[31:0] and inst_pc=pc, then go to HOLD.
  - HOLD: inst_valid = ~redirect_valid (combinational mask). On inst_valid && inst_ready, pc <= pc+4 (wraps mod 2^64) and go to REQ.
- Fetch latency: a response is never expected in the same cycle as request acceptance. Throughput is at most one instruction per 3 cycles (no overlap).
- Address stability: imem_req_addr is held stable while REQ waits for ready. A redirect is the only event allowed to change it.
- Redirect has priority over all other events:
  - REQ, no handshake this cycle: pc <= redirect_pc, stay in REQ.
  - REQ, handshake this cycle: pc <= redirect_pc, drop <= 1, go to WAIT.
  - WAIT, no response this cycle: pc <= redirect_pc, drop <= 1.
  - WAIT, response this cycle: discard the response, pc <= redirect_pc, drop <= 0, go to REQ.
  - HOLD: inst_valid is masked, so no handshake occurs. pc <= redirect_pc, go to REQ; the held instruction is squashed.
  - IDLE: pc <= redirect_pc.
- WAIT with drop=1 and imem_resp_valid: discard the data, drop <= 0, go to REQ. Never more than one outstanding request.
- imem_resp_valid is ignored in IDLE, REQ and HOLD; stale responses after reset are dropped.
- inst and inst_pc hold their values outside HOLD; decode must qualify them with inst_valid.
- Reset mid-operation: returns to IDLE with pc=RESET_PC and drop cleared, regardless of outstanding request.

Test Plan:
- Reset then ready=1, 1-cycle memory, mem[0x80000000]=64'h00000297_00100093, inst_ready=1 -> first req addr 0x80000000. Delivers inst 0x00100093 @pc 0x80000000, then 0x00000297 @pc 0x80000004 (same 64-bit word fetched again). Next req addr 0x80000008.
- imem_req_ready low 4 cycles -> imem_req_valid stays 1 and addr stays 0x80000000 throughout. Exactly one request accepted.
- Redirect to 0x80000103 while in WAIT, response 2 cycles later -> that response discarded, no inst_valid. Next req addr 0x80000100, then inst_pc=0x80000100.
- HOLD with inst_ready=0 for 3 cycles, then redirect_valid and inst_ready both 1 -> inst_valid=0 that cycle, no handshake. Next req for redirect target.
- rst asserted while in WAIT, stale resp_valid arrives 1 cycle after rst falls -> ignored. First req addr is RESET_PC.
- PC=64'hFFFF_FFFF_FFFF_FFFC accepted by decode -> next req addr 64'h0.

Source files
------------

// File: rtl/ysyx_22040632_ifu.sv
// Instruction fetch unit: holds the PC, fetches one aligned 64-bit word at a time,
// extracts the 32-bit instruction for decode and squashes wrong-path fetches on redirect.
module ysyx_22040632_ifu #(
    parameter int                XLEN     = 64,
    parameter logic [XLEN-1:0]   RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_pc,
    output logic [31:0]     inst
);

    // state | meaning
    // IDLE  | just out of reset, no request issued yet
    // REQ   | request presented, waiting for imem_req_ready
    // WAIT  | request accepted, waiting for the single response
    // HOLD  | instruction presented to decode, waiting for inst_ready
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic            drop;
    logic            drop_nxt;
    logic            capture;
    logic [XLEN-1:0] redirect_tgt;
    logic            req_fire;
    logic            inst_fire;
    logic [31:0]     resp_word;

    assign redirect_tgt   = redirect_pc & ALIGN_MASK;
    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = {pc[XLEN-1:3], 3'b000};
    // Redirect masks the handshake so a squashed instruction is never consumed.
    assign inst_valid     = (state == HOLD) && !redirect_valid;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign inst_fire      = inst_valid && inst_ready;
    assign resp_word      = pc[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        drop_nxt  = drop;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = REQ;
                if (redirect_valid) begin
                    pc_nxt = redirect_tgt;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_tgt;
                    if (req_fire) begin
                        drop_nxt  = 1'b1;
                        state_nxt = WAIT;
                    end
                end else if (req_fire) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_tgt;
                    if (imem_resp_valid) begin
                        drop_nxt  = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        drop_nxt  = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (drop) begin
                        drop_nxt  = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_tgt;
                    state_nxt = REQ;
                end else if (inst_fire) begin
                    pc_nxt    = pc + XLEN'(4);
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC & ALIGN_MASK;
            drop    <= 1'b0;
            inst_pc <= '0;
            inst    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            drop  <= drop_nxt;
            if (capture) begin
                inst_pc <= pc;
                inst    <= resp_word;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040632_ifu.sv
// Directed bench for ysyx_22040632_ifu: linear cycle-by-cycle stimulus with
// hand-computed expectations checked by immediate assertions.
module tb_ysyx_22040632_ifu;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [63:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [63:0] inst_pc;
    logic [31:0] inst;

    int n_pass;
    int n_total;

    ysyx_22040632_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_pc         (inst_pc),
        .inst            (inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: one fixed word at 0x80000000, elsewhere {addr+4, addr} in the low 32 bits.
    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        logic [31:0] lo;
        if (a == 64'h0000_0000_8000_0000) return 64'h00000297_00100093;
        lo = a[31:0];
        return {lo + 32'd4, lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full fetch starting in REQ with an accepted request and a next-cycle response.
    task automatic do_fetch(input string tag, input logic [63:0] exp_addr,
                            input logic [31:0] exp_inst, input logic [63:0] exp_pc);
        chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'd1);
        chk({tag, "_req_addr"}, imem_req_addr, exp_addr);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        chk({tag, "_wait_novalid"}, 64'(imem_req_valid), 64'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_rd(exp_addr);
        tick();
        imem_resp_valid = 1'b0;
        chk({tag, "_inst_valid"}, 64'(inst_valid), 64'd1);
        chk({tag, "_inst"}, 64'(inst), 64'(exp_inst));
        chk({tag, "_inst_pc"}, inst_pc, exp_pc);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    initial begin
        n_pass          = 0;
        n_total         = 0;
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        inst_ready      = 1'b0;

        tick();
        tick();
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst_pc", inst_pc, 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);

        // Release reset: IDLE for one cycle, then REQ; hold ready low 4 cycles.
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("stall_req_valid", 64'(imem_req_valid), 64'd1);
            chk("stall_req_addr", imem_req_addr, 64'h8000_0000);
            tick();
        end
        do_fetch("f0", 64'h8000_0000, 32'h00100093, 64'h8000_0000);
        do_fetch("f1", 64'h8000_0000, 32'h00000297, 64'h8000_0004);
        chk("f2_req_addr", imem_req_addr, 64'h8000_0008);

        // Redirect during WAIT, response arrives two cycles later and is dropped.
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0103;
        tick();
        redirect_valid = 1'b0;
        chk("rw_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rw_inst_valid0", 64'(inst_valid), 64'd0);
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_rd(64'h8000_0008);
        tick();
        imem_resp_valid = 1'b0;
        chk("rw_inst_valid1", 64'(inst_valid), 64'd0);
        do_fetch("rw", 64'h8000_0100, 32'h8000_0100, 64'h8000_0100);

        // HOLD stalled by decode, then redirect together with inst_ready.
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_rd(64'h8000_0100);
        tick();
        imem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_inst_valid", 64'(inst_valid), 64'd1);
            chk("hold_inst", 64'(inst), 64'h8000_0104);
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        inst_ready     = 1'b1;
        #1;
        chk("hold_mask", 64'(inst_valid), 64'd0);
        tick();
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        chk("hold_rd_req_valid", 64'(imem_req_valid), 64'd1);
        chk("hold_rd_req_addr", imem_req_addr, 64'h8000_0200);
        chk("hold_rd_inst_kept", 64'(inst), 64'h8000_0104);

        // Reset while in WAIT; stale responses after reset are ignored.
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("mid_rst_inst_pc", inst_pc, 64'd0);
        rst             = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_rd(64'h8000_0200);
        tick();
        chk("stale_req_valid", 64'(imem_req_valid), 64'd1);
        chk("stale_req_addr", imem_req_addr, 64'h8000_0000);
        tick();
        imem_resp_valid = 1'b0;
        chk("stale_inst_valid", 64'(inst_valid), 64'd0);
        chk("stale_still_req", 64'(imem_req_valid), 64'd1);
        chk("stale_addr_kept", imem_req_addr, 64'h8000_0000);

        // Redirect in REQ without handshake, low PC bits ignored; then PC wrap.
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        do_fetch("wrap", 64'hFFFF_FFFF_FFFF_FFF8, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_req_addr", imem_req_addr, 64'h0);

        // Redirect coinciding with request handshake: the in-flight response is dropped.
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0010;
        tick();
        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_rd(64'h0);
        tick();
        imem_resp_valid = 1'b0;
        chk("rq_drop_inst_valid", 64'(inst_valid), 64'd0);
        chk("rq_drop_req_addr", imem_req_addr, 64'h8000_0010);

        // Redirect coinciding with the response: response discarded, drop stays clear.
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_rd(64'h8000_0010);
        redirect_valid  = 1'b1;
        redirect_pc     = 64'h8000_0020;
        tick();
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        chk("wr_inst_valid", 64'(inst_valid), 64'd0);
        do_fetch("wr", 64'h8000_0020, 32'h8000_0020, 64'h8000_0020);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
